// File: rtl/booth_pkg.sv
// Shared types for the Booth datapath shift register.
// Holds the shift-engine FSM states and direction encodings.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bsr_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/bsr_shift_step.sv
// One-position shift of the register contents.
// Shared by the single-step commands and the multi-step engine.
module bsr_shift_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_p,
    input  logic             i_s_in,
    input  logic             i_dir,
    input  logic             i_arith,
    output logic [WIDTH-1:0] o_next_p,
    output logic             o_out_bit
);

    logic w_fill;

    // Right fill is the sign bit for arithmetic shifts, else the serial input
    assign w_fill = i_arith ? i_p[WIDTH-1] : i_s_in;

    // Select the shifted word and the bit that falls off the end
    always_comb begin
        o_next_p  = '0;
        o_out_bit = 1'b0;
        if (i_dir == DIR_LEFT) begin
            o_next_p  = {i_p[WIDTH-2:0], i_s_in};
            o_out_bit = i_p[WIDTH-1];
        end else begin
            o_next_p  = {w_fill, i_p[WIDTH-1:1]};
            o_out_bit = i_p[0];
        end
    end

endmodule

// File: rtl/booth_shift_register.sv
// Parametrised P/A/Q shift register with clear, load, single and multi-step shifts.
// Optional zero flag built when BSR_ZERO_FLAG_EN is defined.
module booth_shift_register
    import booth_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in,
    input  logic             clr,
    input  logic             ld,
    input  logic             shr,
    input  logic             shl,
    input  logic             arith,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] p_out,
    output logic             s_out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    bsr_state_t       r_state;
    bsr_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] w_p_nxt;
    logic             r_sout;
    logic             w_sout_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_arith;
    logic             w_arith_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_step_dir;
    logic             w_step_arith;
    logic [WIDTH-1:0] w_step_p;
    logic             w_step_bit;

    // Multi-step uses the latched controls; idle single steps use live ones
    always_comb begin
        w_step_dir   = DIR_RIGHT;
        w_step_arith = arith;
        if (r_state == ST_SHIFT) begin
            w_step_dir   = r_dir;
            w_step_arith = r_arith;
        end else if (shl && !shr) begin
            w_step_dir   = DIR_LEFT;
        end
    end

    bsr_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_p      (r_p),
        .i_s_in   (s_in),
        .i_dir    (w_step_dir),
        .i_arith  (w_step_arith),
        .o_next_p (w_step_p),
        .o_out_bit(w_step_bit)
    );

    // Next-state and datapath decode; in IDLE clr > ld > start > shr > shl
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_sout_nxt  = r_sout;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_arith_nxt = r_arith;
        unique case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_p_nxt    = '0;
                    w_sout_nxt = 1'b0;
                end else if (ld) begin
                    w_p_nxt = p_in;
                end else if (start) begin
                    w_dir_nxt   = dir;
                    w_arith_nxt = arith;
                    w_cnt_nxt   = count;
                    w_state_nxt = (count != '0) ? ST_SHIFT : ST_DONE;
                end else if (shr != shl) begin
                    w_p_nxt    = w_step_p;
                    w_sout_nxt = w_step_bit;
                end
            end
            ST_SHIFT: begin
                if (clr) begin
                    w_p_nxt     = '0;
                    w_sout_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_p_nxt    = w_step_p;
                    w_sout_nxt = w_step_bit;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_p     <= '0;
            r_sout  <= 1'b0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_sout  <= w_sout_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_arith <= w_arith_nxt;
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign p_out = r_p;
    assign s_out = r_sout;
    assign busy  = r_busy;
    assign done  = r_done;

`ifdef BSR_ZERO_FLAG_EN
    logic r_zero;

    // Zero flag tracks the value being written so it lines up with p_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b1;
        end else begin
            r_zero <= (w_p_nxt == '0);
        end
    end

    assign zero = r_zero;
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_booth_shift_register.sv
// Scoreboard bench for booth_shift_register (WIDTH=8).
// Expected outputs are queued per driven cycle and popped after the edge.
module tb_booth_shift_register;

    logic       clk;
    logic       rst;
    logic [7:0] p_in;
    logic       s_in;
    logic       clr;
    logic       ld;
    logic       shr;
    logic       shl;
    logic       arith;
    logic       start;
    logic       dir;
    logic [3:0] count;
    logic [7:0] p_out;
    logic       s_out;
    logic       busy;
    logic       done;
    logic       zero;

    booth_shift_register #(
        .WIDTH(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .p_in (p_in),
        .s_in (s_in),
        .clr  (clr),
        .ld   (ld),
        .shr  (shr),
        .shl  (shl),
        .arith(arith),
        .start(start),
        .dir  (dir),
        .count(count),
        .p_out(p_out),
        .s_out(s_out),
        .busy (busy),
        .done (done),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        logic       s;
        logic       busy;
        logic       done;
        logic       zero;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_pass;
    int   done_seen;

    // Reference model state: 0 idle, 1 shifting, 2 done
    logic [7:0] m_p;
    logic       m_s;
    int         m_st;
    int         m_cnt;
    logic       m_dir;
    logic       m_ar;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic exp_zero();
`ifdef BSR_ZERO_FLAG_EN
        return (m_p == 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        m_p = 8'h00; m_s = 1'b0; m_st = 0;
        m_cnt = 0; m_dir = 1'b0; m_ar = 1'b0;
    endtask

    task automatic m_right(input logic a, input logic si);
        logic fill;
        fill = a ? m_p[7] : si;
        m_s  = m_p[0];
        m_p  = (m_p >> 1) | (fill ? 8'h80 : 8'h00);
    endtask

    task automatic m_left(input logic si);
        m_s = m_p[7];
        m_p = (m_p << 1) | {7'd0, si};
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_p"}, 32'(p_out), 32'(m_p));
        chk({tag, "_s"}, 32'(s_out), 32'(m_s));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_zero"}, 32'(zero), 32'(exp_zero()));
    endtask

    // Drive one cycle, advance the model, queue and then check expectation
    task automatic cyc(input string tag, input logic c, input logic l,
                       input logic sr, input logic sl, input logic st,
                       input logic d, input logic a, input logic si,
                       input logic [7:0] pi, input logic [3:0] cn);
        exp_t e;
        exp_t g;
        clr = c; ld = l; shr = sr; shl = sl; start = st;
        dir = d; arith = a; s_in = si; p_in = pi; count = cn;
        if (m_st == 0) begin
            if (c) begin
                m_p = 8'h00; m_s = 1'b0;
            end else if (l) begin
                m_p = pi;
            end else if (st) begin
                m_dir = d; m_ar = a; m_cnt = int'(cn);
                m_st = (cn == 4'd0) ? 2 : 1;
            end else if (sr && !sl) begin
                m_right(a, si);
            end else if (sl && !sr) begin
                m_left(si);
            end
        end else if (m_st == 1) begin
            if (c) begin
                m_p = 8'h00; m_s = 1'b0; m_st = 0; m_cnt = 0;
            end else begin
                if (m_dir) m_left(si);
                else m_right(m_ar, si);
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_st = 2;
            end
        end else begin
            m_st = 0;
        end
        e.p = m_p; e.s = m_s;
        e.busy = (m_st == 1); e.done = (m_st == 2);
        e.zero = exp_zero();
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        if (done) done_seen++;
        chk({tag, "_p"}, 32'(p_out), 32'(g.p));
        chk({tag, "_s"}, 32'(s_out), 32'(g.s));
        chk({tag, "_busy"}, 32'(busy), 32'(g.busy));
        chk({tag, "_done"}, 32'(done), 32'(g.done));
        chk({tag, "_zero"}, 32'(zero), 32'(g.zero));
    endtask

    task automatic idle(input string tag, input logic si);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, si, 8'h00, 4'd0);
    endtask

    task automatic load(input logic [7:0] v);
        cyc("ld", 0, 1, 0, 0, 0, 0, 0, 0, v, 4'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; done_seen = 0;
        rst = 1'b1; clr = 0; ld = 0; shr = 0; shl = 0; start = 0;
        dir = 0; arith = 0; s_in = 0; p_in = 8'h00; count = 4'd0;
        m_reset();
        #3;
        cmp_all("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single arithmetic right shift
        load(8'b1001_0110);
        cyc("t1", 0, 0, 1, 0, 0, 0, 1, 0, 8'h00, 4'd0);
        chk("t1_lit_p", 32'(p_out), 32'h0000_00CB);
        chk("t1_lit_s", 32'(s_out), 32'd0);

        // Arithmetic right by 3 via the engine
        load(8'b1001_0110);
        cyc("t2_start", 0, 0, 0, 0, 1, 0, 1, 0, 8'h00, 4'd3);
        chk("t2_p0", 32'(p_out), 32'h96);
        idle("t2_s1", 0);
        chk("t2_lit1", 32'(p_out), 32'hCB);
        idle("t2_s2", 0);
        chk("t2_lit2", 32'(p_out), 32'hE5);
        idle("t2_s3", 0);
        chk("t2_lit3", 32'(p_out), 32'hF2);
        chk("t2_sout", 32'(s_out), 32'd1);
        chk("t2_done", 32'(done), 32'd1);
        idle("t2_after", 0);

        // Left by 2 with s_in=1
        load(8'b0000_0001);
        done_seen = 0;
        cyc("t3_start", 0, 0, 0, 0, 1, 1, 0, 1, 8'h00, 4'd2);
        for (int i = 0; i < 4; i++) idle("t3", 1'b1);
        chk("t3_lit_p", 32'(p_out), 32'h07);
        chk("t3_lit_s", 32'(s_out), 32'd0);
        chk("t3_done_cnt", 32'(done_seen), 32'd1);

        // Zero-count start, then conflicting single steps
        cyc("t4_start", 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 4'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_lit_p", 32'(p_out), 32'h07);
        idle("t4_idle", 0);
        cyc("t4_hold", 0, 0, 1, 1, 0, 0, 0, 1, 8'h00, 4'd0);
        chk("t4_hold_lit", 32'(p_out), 32'h07);

        // Abort by clr on second busy cycle
        load(8'hA5);
        done_seen = 0;
        cyc("t5_start", 0, 0, 0, 0, 1, 0, 0, 1, 8'h00, 4'd5);
        idle("t5_b1", 1'b1);
        cyc("t5_clr", 1, 1, 1, 0, 1, 0, 0, 1, 8'h3C, 4'd3);
        for (int i = 0; i < 5; i++) idle("t5_post", 0);
        chk("t5_nodone", 32'(done_seen), 32'd0);

        // Async reset mid-shift
        load(8'h5A);
        cyc("t5r_start", 0, 0, 0, 0, 1, 1, 0, 1, 8'h00, 4'd6);
        idle("t5r_b1", 1'b1);
        rst = 1'b1;
        #1;
        m_reset();
        cmp_all("t5r_rst");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) idle("t5r_post", 0);
        chk("t5r_nodone", 32'(done_seen), 32'd0);

        // Zero flag walk: 0x80 shifted out logically
        load(8'h80);
        for (int i = 0; i < 8; i++)
            cyc("t6", 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 4'd0);
        chk("t6_lit_p", 32'(p_out), 32'h00);

        // Count beyond width: arithmetic saturates, logical takes s_in history
        load(8'h80);
        cyc("ovr_a", 0, 0, 0, 0, 1, 0, 1, 0, 8'h00, 4'd10);
        for (int i = 0; i < 11; i++) idle("ovr_a", 0);
        chk("ovr_a_lit", 32'(p_out), 32'hFF);
        load(8'h00);
        cyc("ovr_l", 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 4'd12);
        for (int i = 0; i < 13; i++) idle("ovr_l", 1'($urandom_range(1)));

        // Random command mix
        for (int i = 0; i < 200; i++) begin
            cyc("rnd",
                1'($urandom_range(15) == 0),
                1'($urandom_range(5) == 0),
                1'($urandom_range(1)),
                1'($urandom_range(1)),
                1'($urandom_range(6) == 0),
                1'($urandom_range(1)),
                1'($urandom_range(1)),
                1'($urandom_range(1)),
                8'($urandom),
                4'($urandom_range(10)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
